// File: rtl/tile_pixel_fifo.sv
// rtl/tile_pixel_fifo.sv - Row-in / pixel-out FIFO between tile fetcher and pixel mixer.
// Unpacks one bitplane row per push; applies the palette at the output so palette writes act immediately.
module tile_pixel_fifo #(
    parameter int  PIXEL_BITS   = 2,
    parameter int  ROW_SIZE     = 8,
    parameter int  DEPTH        = 16,
    parameter int  NUM_PALETTES = 3,
    parameter int  COLOR_BITS   = 2,
    localparam int PS           = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1,
    localparam int LW           = $clog2(DEPTH + 1),
    localparam int PW           = NUM_PALETTES * (2 ** PIXEL_BITS) * COLOR_BITS
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic                           row_valid,
    output logic                           row_ready,
    input  logic [PIXEL_BITS*ROW_SIZE-1:0] row_planes,
    input  logic                           row_hflip,
    input  logic [PS-1:0]                  row_pal_sel,
    input  logic [PW-1:0]                  palettes,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [COLOR_BITS-1:0]          pix_color,
    output logic [PIXEL_BITS-1:0]          pix_index,
    output logic [PS-1:0]                  pix_pal,
    output logic [LW-1:0]                  level
);

    localparam int AW = $clog2(DEPTH);

    logic [PIXEL_BITS-1:0] idx_mem_q [DEPTH];
    logic [PS-1:0]         pal_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic [PIXEL_BITS-1:0] row_idx [ROW_SIZE];
    logic [PS-1:0]         row_pal;
    logic [PIXEL_BITS-1:0] head_idx;
    logic [PS-1:0]         head_pal;
    logic                  push;
    logic                  pop;

    // Room for a whole row is judged on the registered level only; a same-cycle pop does not count.
    assign row_ready = !flush && (level_q <= LW'(DEPTH - ROW_SIZE));
    assign pix_valid = (level_q != '0);
    assign level     = level_q;
    assign push      = row_valid && row_ready;
    assign pop       = pix_valid && pix_ready && !flush;

    // Pixel 0 normally comes from the MSB of each plane; hflip takes it from the LSB.
    always_comb begin
        for (int i = 0; i < ROW_SIZE; i++) begin
            row_idx[i] = '0;
            for (int p = 0; p < PIXEL_BITS; p++) begin
                row_idx[i][p] = row_planes[p*ROW_SIZE + (row_hflip ? i : ROW_SIZE - 1 - i)];
            end
        end
    end

    assign row_pal = (int'(row_pal_sel) >= NUM_PALETTES) ? '0 : row_pal_sel;

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                idx_mem_q[wr_ptr_q + AW'(i)] <= row_idx[i];
                pal_mem_q[wr_ptr_q + AW'(i)] <= row_pal;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(ROW_SIZE);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (push ? LW'(ROW_SIZE) : LW'(0)) - (pop ? LW'(1) : LW'(0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        head_idx  = idx_mem_q[rd_ptr_q];
        head_pal  = pal_mem_q[rd_ptr_q];
        pix_index = '0;
        pix_pal   = '0;
        pix_color = '0;
        if (pix_valid) begin
            pix_index = head_idx;
            pix_pal   = head_pal;
            pix_color = palettes[(int'(head_pal) * (2 ** PIXEL_BITS) + int'(head_idx)) * COLOR_BITS +: COLOR_BITS];
        end
    end

    always @(posedge clk) begin
        if (reset_n) assert (level_q <= LW'(DEPTH));
    end

endmodule

// File: tb/tb_tile_pixel_fifo.sv
// tb/tb_tile_pixel_fifo.sv - Directed and randomized bench for tile_pixel_fifo against a queue model.
module tb_tile_pixel_fifo;

    localparam int PB = 2, RS = 8, DEPTH = 16, NP = 3, CB = 2, PS = 2, LW = 5;
    localparam int NE = 1 << PB;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic flush = 1'b0, row_valid = 1'b0, row_hflip = 1'b0, pix_ready = 1'b0;
    logic [PB*RS-1:0]    row_planes = '0;
    logic [PS-1:0]       row_pal_sel = '0;
    logic [NP*NE*CB-1:0] palettes;
    logic                row_ready, pix_valid;
    logic [CB-1:0]       pix_color;
    logic [PB-1:0]       pix_index;
    logic [PS-1:0]       pix_pal;
    logic [LW-1:0]       level;

    tile_pixel_fifo dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .row_valid(row_valid), .row_ready(row_ready), .row_planes(row_planes),
        .row_hflip(row_hflip), .row_pal_sel(row_pal_sel), .palettes(palettes),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
        .pix_index(pix_index), .pix_pal(pix_pal), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PB-1:0] idx;
        logic [PS-1:0] pal;
    } pix_t;

    logic [CB-1:0] pal_tab [NP][NE];
    pix_t          model_q[$];
    logic [PB-1:0] popped_idx[$];
    logic [CB-1:0] popped_color[$];
    int            n_checks = 0;
    int            n_pass = 0;

    always_comb begin
        palettes = '0;
        for (int k = 0; k < NP; k++)
            for (int i = 0; i < NE; i++)
                palettes[(k*NE + i)*CB +: CB] = pal_tab[k][i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // One clock: compare outputs with the model at the falling edge, then advance the model.
    task automatic cycle(output bit pushed);
        bit   pop;
        pix_t h;
        int   b;
        int   sel;
        pix_t row [RS];
        @(negedge clk);
        check("level", level, model_q.size());
        check("row_ready", row_ready, !flush && model_q.size() <= DEPTH - RS);
        check("pix_valid", pix_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            h = model_q[0];
            check("pix_index", pix_index, h.idx);
            check("pix_pal", pix_pal, h.pal);
            check("pix_color", pix_color, pal_tab[h.pal][h.idx]);
        end else begin
            check("empty_index", pix_index, 0);
            check("empty_pal", pix_pal, 0);
            check("empty_color", pix_color, 0);
        end
        pushed = row_valid && !flush && model_q.size() <= DEPTH - RS;
        pop = pix_ready && !flush && model_q.size() != 0;
        if (pop) begin
            popped_idx.push_back(pix_index);
            popped_color.push_back(pix_color);
        end
        sel = (int'(row_pal_sel) >= NP) ? 0 : int'(row_pal_sel);
        for (int i = 0; i < RS; i++) begin
            b = row_hflip ? i : RS - 1 - i;
            row[i].pal = PS'(sel);
            for (int p = 0; p < PB; p++) row[i].idx[p] = row_planes[p*RS + b];
        end
        @(posedge clk);
        if (flush) model_q.delete();
        else begin
            if (pop) void'(model_q.pop_front());
            if (pushed) for (int i = 0; i < RS; i++) model_q.push_back(row[i]);
        end
        #1;
    endtask

    task automatic push_row(input logic [RS-1:0] lo, input logic [RS-1:0] hi,
                            input logic flip, input logic [PS-1:0] sel);
        bit pushed = 0;
        row_planes = {hi, lo};
        row_hflip = flip;
        row_pal_sel = sel;
        row_valid = 1'b1;
        for (int t = 0; t < 100 && !pushed; t++) cycle(pushed);
        if (!pushed) check("push_timeout", 0, 1);
        row_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bit pushed;
        popped_idx.delete();
        popped_color.delete();
        pix_ready = 1'b1;
        for (int t = 0; t < 4*n + 20 && popped_idx.size() < n; t++) cycle(pushed);
        pix_ready = 1'b0;
        if (popped_idx.size() < n) check("drain_timeout", popped_idx.size(), n);
    endtask

    task automatic check_seq(input string tag, input int exp [RS]);
        for (int i = 0; i < RS; i++) begin
            if (i < popped_idx.size()) begin
                check({tag, "_idx"}, popped_idx[i], exp[i]);
                check({tag, "_color"}, popped_color[i], exp[i]);
            end
        end
    endtask

    initial begin
        bit pushed;
        int exp2 [RS];
        int exp3a [RS];
        int exp3b [RS];
        exp2  = '{3, 2, 1, 0, 0, 1, 2, 3};
        exp3a = '{1, 1, 1, 1, 0, 0, 0, 0};
        exp3b = '{0, 0, 0, 0, 1, 1, 1, 1};
        for (int k = 0; k < NP; k++)
            for (int i = 0; i < NE; i++) pal_tab[k][i] = CB'(i);

        // T1 reset
        #1 reset_n = 1'b0;
        #2;
        check("rst_level", level, 0);
        check("rst_row_ready", row_ready, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_color", pix_color, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        cycle(pushed);
        cycle(pushed);

        // T2 unpack with identity palette (E4)
        push_row(8'hA5, 8'hC3, 1'b0, 2'd0);
        check("t2_level", level, 8);
        drain(8);
        check_seq("t2", exp2);
        check("t2_level_end", level, 0);

        // T3 hflip
        push_row(8'hF0, 8'h00, 1'b0, 2'd0);
        drain(8);
        check_seq("t3_noflip", exp3a);
        push_row(8'hF0, 8'h00, 1'b1, 2'd0);
        drain(8);
        check_seq("t3_flip", exp3b);

        // T4 full and backpressure
        pix_ready = 1'b0;
        push_row(RS'($urandom), RS'($urandom), 1'b0, 2'd1);
        push_row(RS'($urandom), RS'($urandom), 1'b1, 2'd2);
        check("t4_level_full", level, 16);
        check("t4_ready_full", row_ready, 0);
        row_planes = PB*RS'($urandom);
        row_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cycle(pushed);
            check("t4_held", pushed, 0);
        end
        pix_ready = 1'b1;
        pushed = 0;
        for (int t = 0; t < 30 && !pushed; t++) cycle(pushed);
        check("t4_third_accepted", pushed, 1);
        row_valid = 1'b0;
        drain(model_q.size());

        // T5 simultaneous push and pop at level 8, then a wrapping stream
        push_row(RS'($urandom), RS'($urandom), 1'b0, 2'd0);
        row_planes = PB*RS'($urandom);
        row_valid = 1'b1;
        pix_ready = 1'b1;
        cycle(pushed);
        check("t5_pushed", pushed, 1);
        check("t5_level", level, 15);
        row_valid = 1'b0;
        for (int r = 0; r < 6; r++) begin
            pix_ready = 1'b1;
            push_row(RS'($urandom), RS'($urandom), 1'($urandom), PS'($urandom_range(0, 3)));
        end
        drain(model_q.size());

        // T6 palette change mid-drain, then flush discarding a row
        push_row(8'h3C, 8'h5A, 1'b0, 2'd2);
        drain(3);
        for (int i = 0; i < NE; i++) pal_tab[2][i] = ~pal_tab[2][i];
        #1;
        check("t6_new_shade", pix_color, pal_tab[2][pix_index]);
        drain(2);
        row_planes = PB*RS'($urandom);
        row_valid = 1'b1;
        flush = 1'b1;
        cycle(pushed);
        flush = 1'b0;
        row_valid = 1'b0;
        check("t6_flush_level", level, 0);
        check("t6_flush_valid", pix_valid, 0);
        cycle(pushed);

        // Asynchronous reset in the middle of a buffered row
        push_row(RS'($urandom), RS'($urandom), 1'b0, 2'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_valid", pix_valid, 0);
        model_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            row_valid   = ($urandom_range(0, 2) != 0);
            pix_ready   = ($urandom_range(0, 3) != 0);
            row_planes  = PB*RS'($urandom);
            row_hflip   = 1'($urandom);
            row_pal_sel = PS'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 10) == 0)
                pal_tab[$urandom_range(0, NP-1)][$urandom_range(0, NE-1)] = CB'($urandom);
            cycle(pushed);
        end
        flush = 1'b0;
        row_valid = 1'b0;
        drain(model_q.size());
        check("final_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
